// File: rtl/cme_pkg.sv
// cme_pkg
// Shared definitions for the candidate metric evaluator:
//   cme_aw / cme_jw : column / row index widths derived from A and J
//   cme_state_e     : evaluator FSM state encoding
//   SI_*            : generator phase codes carried on state_in
//   STAT_W          : width of the statistics counters
package cme_pkg;

  function automatic int cme_aw(input int a);
    return $clog2(a) + 1;
  endfunction

  function automatic int cme_jw(input int j);
    return $clog2(j) + 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cme_state_e;

  localparam logic [1:0] SI_IDLE  = 2'd0;
  localparam logic [1:0] SI_START = 2'd1;
  localparam logic [1:0] SI_ONE   = 2'd2;
  localparam logic [1:0] SI_TWO   = 2'd3;

  localparam int STAT_W = 16;

endpackage

// File: rtl/cme_metric_table.sv
// cme_metric_table
// J x A register file of signed MW-bit metrics, one write port and four
// combinational read ports. Out-of-range reads return 0 and out-of-range
// writes are dropped, so the caller never indexes past the array.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears table)
//   i_wr_en/row/col/data  write port
//   i_rd_row/i_rd_col     four read addresses (packed, port p in slot p)
//   o_rd_data             four read results
module cme_metric_table
  import cme_pkg::*;
#(
  parameter int J  = 14,
  parameter int A  = 2,
  parameter int MW = 16,
  localparam int AW = cme_aw(A),
  localparam int JW = cme_jw(J)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [JW-1:0]       i_wr_row,
  input  logic [AW-1:0]       i_wr_col,
  input  logic [MW-1:0]       i_wr_data,
  input  logic [3:0][JW-1:0]  i_rd_row,
  input  logic [3:0][AW-1:0]  i_rd_col,
  output logic [3:0][MW-1:0]  o_rd_data
);

  // index widths the array itself needs; the extra top bit of the ports
  // only exists to express out-of-range values
  localparam int RIW = (J > 1) ? $clog2(J) : 1;
  localparam int CIW = (A > 1) ? $clog2(A) : 1;
  localparam logic [JW-1:0] J_LIM = JW'(J);
  localparam logic [AW-1:0] A_LIM = AW'(A);

  logic [MW-1:0] r_tbl [J][A];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < J; r++) begin
        for (int c = 0; c < A; c++) begin
          r_tbl[r][c] <= '0;
        end
      end
    end else if (i_wr_en && (i_wr_row < J_LIM) && (i_wr_col < A_LIM)) begin
      r_tbl[i_wr_row[RIW-1:0]][i_wr_col[CIW-1:0]] <= i_wr_data;
    end
  end

  always_comb begin
    for (int p = 0; p < 4; p++) begin
      o_rd_data[p] = '0;
      if ((i_rd_row[p] < J_LIM) && (i_rd_col[p] < A_LIM)) begin
        o_rd_data[p] = r_tbl[i_rd_row[p][RIW-1:0]][i_rd_col[p][CIW-1:0]];
      end
    end
  end

endmodule

// File: rtl/candidate_metric_eval.sv
// candidate_metric_eval
// Scores candidate vectors streamed from an index generator against a
// metric table and keeps the best (highest) one seen in the current run.
// Each candidate is base + T[mul1] - T[div1] (+ T[mul2] - T[div2] for
// two-row candidates), summed wide and saturated to MW bits.
// Optional build macro: CME_STATS_EN enables the cand_count / err_count
// statistics counters; without it both ports are tied to 0.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   tbl_wr_*                      metric table write (honoured in IDLE only)
//   base_metric                   initial-vector metric, latched at run start
//   idx_valid, state_in           generator tvalid and phase code
//   mul_/div_row1/2, _col1/2      table indices of the candidate
//   best_metric, best_row/col1/2, best_two   best candidate of the run
//   best_valid                    one-cycle pulse when the run result is final
//   busy                          high outside IDLE
//   cand_count, err_count         statistics
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for idx_valid; table writable
// ST_RUN   | accepting one tuple per cycle while idx_valid stays high
// ST_DRAIN | two cycles letting the 2-stage pipeline empty
// ST_DONE  | best_valid asserted for this single cycle
module candidate_metric_eval
  import cme_pkg::*;
#(
  parameter int J  = 14,
  parameter int A  = 2,
  parameter int MW = 16,
  localparam int AW = cme_aw(A),
  localparam int JW = cme_jw(J)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tbl_wr_en,
  input  logic [JW-1:0]        tbl_wr_row,
  input  logic [AW-1:0]        tbl_wr_col,
  input  logic signed [MW-1:0] tbl_wr_data,
  input  logic signed [MW-1:0] base_metric,
  input  logic                 idx_valid,
  input  logic [1:0]           state_in,
  input  logic [JW-1:0]        mul_row1,
  input  logic [JW-1:0]        mul_row2,
  input  logic [JW-1:0]        div_row1,
  input  logic [JW-1:0]        div_row2,
  input  logic [AW-1:0]        mul_col1,
  input  logic [AW-1:0]        mul_col2,
  input  logic [AW-1:0]        div_col1,
  input  logic [AW-1:0]        div_col2,
  output logic signed [MW-1:0] best_metric,
  output logic [JW-1:0]        best_row1,
  output logic [AW-1:0]        best_col1,
  output logic [JW-1:0]        best_row2,
  output logic [AW-1:0]        best_col2,
  output logic                 best_two,
  output logic                 best_valid,
  output logic                 busy,
  output logic [STAT_W-1:0]    cand_count,
  output logic [STAT_W-1:0]    err_count
);

  localparam int SW = MW + 3;
  localparam logic [JW-1:0] J_LIM = JW'(J);
  localparam logic [AW-1:0] A_LIM = AW'(A);
  localparam logic signed [MW-1:0] M_MAX = {1'b0, {(MW-1){1'b1}}};
  localparam logic signed [MW-1:0] M_MIN = {1'b1, {(MW-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX = {4'b0000, {(MW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {4'b1111, {(MW-1){1'b0}}};
  localparam logic DRAIN_LOAD = 1'b1;

  function automatic logic signed [SW-1:0] sext(input logic signed [MW-1:0] v);
    return {{3{v[MW-1]}}, v};
  endfunction

  cme_state_e r_state;
  logic       r_drain_cnt;
  logic       r_busy;
  logic       r_best_valid;

  logic w_start;
  logic w_accept;
  logic w_two;
  logic w_bad1;
  logic w_bad2;
  logic w_err;

  logic [3:0][JW-1:0] w_rd_row;
  logic [3:0][AW-1:0] w_rd_col;
  logic [3:0][MW-1:0] w_rd_data;

  // stage 1
  logic                 r_s1_valid;
  logic                 r_s1_err;
  logic                 r_s1_two;
  logic signed [MW-1:0] r_s1_m1, r_s1_d1, r_s1_m2, r_s1_d2;
  logic [JW-1:0]        r_s1_r1, r_s1_r2;
  logic [AW-1:0]        r_s1_c1, r_s1_c2;

  // stage 2 / best
  logic signed [MW-1:0] r_base;
  logic                 r_have;
  logic signed [MW-1:0] r_best_metric;
  logic [JW-1:0]        r_best_r1, r_best_r2;
  logic [AW-1:0]        r_best_c1, r_best_c2;
  logic                 r_best_two;

  logic signed [SW-1:0] w_sum;
  logic signed [MW-1:0] w_sat;

  assign w_start  = (r_state == ST_IDLE) && idx_valid;
  assign w_two    = (state_in == SI_TWO);
  assign w_accept = idx_valid && ((r_state == ST_IDLE) || (r_state == ST_RUN)) &&
                    ((state_in == SI_ONE) || (state_in == SI_TWO));

  assign w_bad1 = (mul_row1 >= J_LIM) || (mul_col1 >= A_LIM) ||
                  (div_row1 >= J_LIM) || (div_col1 >= A_LIM);
  assign w_bad2 = (mul_row2 >= J_LIM) || (mul_col2 >= A_LIM) ||
                  (div_row2 >= J_LIM) || (div_col2 >= A_LIM);
  // second-row fields are don't-care for single-row candidates
  assign w_err  = w_bad1 || (w_two && w_bad2);

  assign w_rd_row = {div_row2, mul_row2, div_row1, mul_row1};
  assign w_rd_col = {div_col2, mul_col2, div_col1, mul_col1};

  cme_metric_table #(.J(J), .A(A), .MW(MW)) u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (tbl_wr_en && (r_state == ST_IDLE)),
    .i_wr_row  (tbl_wr_row),
    .i_wr_col  (tbl_wr_col),
    .i_wr_data (tbl_wr_data),
    .i_rd_row  (w_rd_row),
    .i_rd_col  (w_rd_col),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_drain_cnt  <= 1'b0;
      r_busy       <= 1'b0;
      r_best_valid <= 1'b0;
    end else begin
      r_best_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (idx_valid) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!idx_valid) begin
            r_state     <= ST_DRAIN;
            r_drain_cnt <= DRAIN_LOAD;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == 1'b0) begin
            r_state      <= ST_DONE;
            r_best_valid <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // second-row terms are zeroed for single-row candidates so stage 2 can
  // always add all four
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_two   <= 1'b0;
      r_s1_m1    <= '0;
      r_s1_d1    <= '0;
      r_s1_m2    <= '0;
      r_s1_d2    <= '0;
      r_s1_r1    <= '0;
      r_s1_c1    <= '0;
      r_s1_r2    <= '0;
      r_s1_c2    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_err <= w_err;
        r_s1_two <= w_two;
        r_s1_m1  <= w_rd_data[0];
        r_s1_d1  <= w_rd_data[1];
        r_s1_m2  <= w_two ? w_rd_data[2] : '0;
        r_s1_d2  <= w_two ? w_rd_data[3] : '0;
        r_s1_r1  <= mul_row1;
        r_s1_c1  <= mul_col1;
        r_s1_r2  <= w_two ? mul_row2 : '0;
        r_s1_c2  <= w_two ? mul_col2 : '0;
      end
    end
  end

  assign w_sum = sext(r_base) + sext(r_s1_m1) - sext(r_s1_d1) +
                 sext(r_s1_m2) - sext(r_s1_d2);

  always_comb begin
    w_sat = w_sum[MW-1:0];
    if (w_sum > S_MAX) begin
      w_sat = M_MAX;
    end else if (w_sum < S_MIN) begin
      w_sat = M_MIN;
    end
  end

  // pipeline is empty at run start, so the clear never races an update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_base        <= '0;
      r_have        <= 1'b0;
      r_best_metric <= '0;
      r_best_r1     <= '0;
      r_best_c1     <= '0;
      r_best_r2     <= '0;
      r_best_c2     <= '0;
      r_best_two    <= 1'b0;
    end else if (w_start) begin
      r_base        <= base_metric;
      r_have        <= 1'b0;
      r_best_metric <= base_metric;
      r_best_r1     <= '0;
      r_best_c1     <= '0;
      r_best_r2     <= '0;
      r_best_c2     <= '0;
      r_best_two    <= 1'b0;
    end else if (r_s1_valid && !r_s1_err && (!r_have || (w_sat > r_best_metric))) begin
      r_have        <= 1'b1;
      r_best_metric <= w_sat;
      r_best_r1     <= r_s1_r1;
      r_best_c1     <= r_s1_c1;
      r_best_r2     <= r_s1_r2;
      r_best_c2     <= r_s1_c2;
      r_best_two    <= r_s1_two;
    end
  end

`ifdef CME_STATS_EN
  logic [STAT_W-1:0] r_cand_count;
  logic [STAT_W-1:0] r_err_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cand_count <= '0;
      r_err_count  <= '0;
    end else if (r_s1_valid) begin
      if (r_s1_err) begin
        if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
      end else begin
        if (r_cand_count != '1) r_cand_count <= r_cand_count + 1'b1;
      end
    end
  end

  assign cand_count = r_cand_count;
  assign err_count  = r_err_count;
`else
  assign cand_count = '0;
  assign err_count  = '0;
`endif

  assign best_metric = r_best_metric;
  assign best_row1   = r_best_r1;
  assign best_col1   = r_best_c1;
  assign best_row2   = r_best_r2;
  assign best_col2   = r_best_c2;
  assign best_two    = r_best_two;
  assign best_valid  = r_best_valid;
  assign busy        = r_busy;

endmodule

// File: tb/tb_candidate_metric_eval.sv
// tb_candidate_metric_eval
// Bench for candidate_metric_eval (J=14, A=2, MW=16): directed vector table,
// hand-written tie and reset-abort sequences, then randomized runs scored by
// a plain-arithmetic reference model of the best-candidate search.
module tb_candidate_metric_eval;

  localparam int J  = 14;
  localparam int A  = 2;
  localparam int MW = 16;
  localparam int JW = 5;
  localparam int AW = 2;
`ifdef CME_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int si;
    int mr1, mc1, dr1, dc1;
    int mr2, mc2, dr2, dc2;
  } tup_t;

  typedef struct {
    tup_t t;
    int   base;
    int   em, er1, ec1, er2, ec2, etwo;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 tbl_wr_en;
  logic [JW-1:0]        tbl_wr_row;
  logic [AW-1:0]        tbl_wr_col;
  logic signed [MW-1:0] tbl_wr_data;
  logic signed [MW-1:0] base_metric;
  logic                 idx_valid;
  logic [1:0]           state_in;
  logic [JW-1:0]        mul_row1, mul_row2, div_row1, div_row2;
  logic [AW-1:0]        mul_col1, mul_col2, div_col1, div_col2;
  logic signed [MW-1:0] best_metric;
  logic [JW-1:0]        best_row1, best_row2;
  logic [AW-1:0]        best_col1, best_col2;
  logic                 best_two, best_valid, busy;
  logic [15:0]          cand_count, err_count;

  candidate_metric_eval #(.J(J), .A(A), .MW(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_row(tbl_wr_row), .tbl_wr_col(tbl_wr_col),
    .tbl_wr_data(tbl_wr_data), .base_metric(base_metric),
    .idx_valid(idx_valid), .state_in(state_in),
    .mul_row1(mul_row1), .mul_row2(mul_row2), .div_row1(div_row1), .div_row2(div_row2),
    .mul_col1(mul_col1), .mul_col2(mul_col2), .div_col1(div_col1), .div_col2(div_col2),
    .best_metric(best_metric), .best_row1(best_row1), .best_col1(best_col1),
    .best_row2(best_row2), .best_col2(best_col2), .best_two(best_two),
    .best_valid(best_valid), .busy(busy),
    .cand_count(cand_count), .err_count(err_count)
  );

  int   checks = 0;
  int   errors = 0;
  int   T [J][A];
  int   m_cand = 0;
  int   m_err  = 0;
  tup_t run_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit in_rng(input int r, input int c);
    return (r >= 0) && (r < J) && (c >= 0) && (c < A);
  endfunction

  // reference: scan the run's tuples, strict-greater keeps earliest on ties
  task automatic model_run(input int base, output int em, output int er1, output int ec1,
                           output int er2, output int ec2, output int etwo);
    bit have = 0;
    em = base; er1 = 0; ec1 = 0; er2 = 0; ec2 = 0; etwo = 0;
    foreach (run_q[i]) begin
      tup_t t = run_q[i];
      bit   two = (t.si == 3);
      int   m;
      if (t.si < 2) continue;
      if (!in_rng(t.mr1, t.mc1) || !in_rng(t.dr1, t.dc1) ||
          (two && (!in_rng(t.mr2, t.mc2) || !in_rng(t.dr2, t.dc2)))) begin
        m_err++;
        continue;
      end
      m = base + T[t.mr1][t.mc1] - T[t.dr1][t.dc1];
      if (two) m = m + T[t.mr2][t.mc2] - T[t.dr2][t.dc2];
      m = sat(m);
      m_cand++;
      if (!have || m > em) begin
        have = 1; em = m; er1 = t.mr1; ec1 = t.mc1; etwo = two;
        er2 = two ? t.mr2 : 0;
        ec2 = two ? t.mc2 : 0;
      end
    end
  endtask

  task automatic drive_idle();
    idx_valid = 0; state_in = 0; tbl_wr_en = 0;
    mul_row1 = 0; mul_col1 = 0; div_row1 = 0; div_col1 = 0;
    mul_row2 = 0; mul_col2 = 0; div_row2 = 0; div_col2 = 0;
  endtask

  task automatic drive_tuple(input tup_t t);
    state_in = 2'(t.si);
    mul_row1 = JW'(t.mr1); mul_col1 = AW'(t.mc1);
    div_row1 = JW'(t.dr1); div_col1 = AW'(t.dc1);
    mul_row2 = JW'(t.mr2); mul_col2 = AW'(t.mc2);
    div_row2 = JW'(t.dr2); div_col2 = AW'(t.dc2);
  endtask

  task automatic noise_write();
    tbl_wr_en   = 1;
    tbl_wr_row  = JW'($urandom_range(0, J - 1));
    tbl_wr_col  = AW'($urandom_range(0, A - 1));
    tbl_wr_data = MW'($urandom);
  endtask

  task automatic write_tbl(input int r, input int c, input int d);
    tbl_wr_en = 1; tbl_wr_row = JW'(r); tbl_wr_col = AW'(c); tbl_wr_data = MW'(d);
    @(posedge clk); #1;
    tbl_wr_en = 0;
    T[r][c] = d;
  endtask

  // apply run_q back to back, then wait (bounded) for best_valid
  task automatic do_run(input string name, input int base, input bit noise, output int lat);
    bit seen = 0;
    base_metric = MW'(base);
    for (int i = 0; i < run_q.size(); i++) begin
      drive_tuple(run_q[i]);
      idx_valid = 1;
      if (noise && i > 0) noise_write(); else tbl_wr_en = 0;
      @(posedge clk); #1;
      if (i == 0) chk({name, ".busy_run"}, busy, 1);
    end
    idx_valid = 0;
    lat = 0;
    while (lat < 20 && !seen) begin
      if (noise) noise_write();
      @(posedge clk); #1;
      lat++;
      if (best_valid) seen = 1;
    end
    drive_idle();
  endtask

  task automatic check_run(input string name, input int lat, input int em, input int er1,
                           input int ec1, input int er2, input int ec2, input int etwo);
    chk({name, ".latency"}, lat, 3);
    chk({name, ".metric"}, int'(best_metric), em);
    chk({name, ".row1"}, int'(best_row1), er1);
    chk({name, ".col1"}, int'(best_col1), ec1);
    chk({name, ".row2"}, int'(best_row2), er2);
    chk({name, ".col2"}, int'(best_col2), ec2);
    chk({name, ".two"}, int'(best_two), etwo);
    @(posedge clk); #1;
    chk({name, ".pulse_end"}, int'(best_valid), 0);
    chk({name, ".busy_idle"}, int'(busy), 0);
    chk({name, ".metric_hold"}, int'(best_metric), em);
    chk({name, ".cand_count"}, int'(cand_count), STATS ? m_cand : 0);
    chk({name, ".err_count"}, int'(err_count), STATS ? m_err : 0);
  endtask

  vec_t vecs[$];

  function automatic tup_t mk(input int si, input int mr1, input int mc1, input int dr1,
                              input int dc1, input int mr2, input int mc2, input int dr2,
                              input int dc2);
    tup_t t;
    t.si = si; t.mr1 = mr1; t.mc1 = mc1; t.dr1 = dr1; t.dc1 = dc1;
    t.mr2 = mr2; t.mc2 = mc2; t.dr2 = dr2; t.dc2 = dc2;
    return t;
  endfunction

  function automatic vec_t mv(input tup_t t, input int base, input int em, input int er1,
                              input int ec1, input int er2, input int ec2, input int etwo);
    vec_t v;
    v.t = t; v.base = base; v.em = em; v.er1 = er1; v.ec1 = ec1;
    v.er2 = er2; v.ec2 = ec2; v.etwo = etwo;
    return v;
  endfunction

  initial begin
    int lat, em, er1, ec1, er2, ec2, etwo, nt, pulses;
    for (int r = 0; r < J; r++) for (int c = 0; c < A; c++) T[r][c] = 0;
    drive_idle();
    tbl_wr_row = 0; tbl_wr_col = 0; tbl_wr_data = 0; base_metric = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.busy", int'(busy), 0);
    chk("reset.best_valid", int'(best_valid), 0);
    chk("reset.metric", int'(best_metric), 0);
    chk("reset.two", int'(best_two), 0);
    chk("reset.cand_count", int'(cand_count), 0);
    chk("reset.err_count", int'(err_count), 0);
    rst_n = 1;
    @(posedge clk); #1;

    write_tbl(3, 1, 100);
    write_tbl(2, 1, 20);
    write_tbl(5, 1, 30);
    write_tbl(7, 0, -50);
    write_tbl(0, 0, 32767);
    write_tbl(1, 0, 32767);
    write_tbl(4, 0, -32768);
    write_tbl(6, 0, -32768);
    write_tbl(10, 1, 40);

    vecs.push_back(mv(mk(2, 3,1,3,0, 0,0,0,0),     0,   100,  3,1,0,0,0));
    vecs.push_back(mv(mk(3, 2,1,2,0, 5,1,5,0),     0,    50,  2,1,5,1,1));
    vecs.push_back(mv(mk(3, 0,0,8,0, 1,0,9,0), 32000, 32767,  0,0,1,0,1));
    vecs.push_back(mv(mk(3, 4,0,0,0, 6,0,1,0),-32768,-32768,  4,0,6,0,1));
    vecs.push_back(mv(mk(2, 7,0,3,1, 0,0,0,0),    10,  -140,  7,0,0,0,0));
    vecs.push_back(mv(mk(1, 3,1,3,0, 0,0,0,0),   123,   123,  0,0,0,0,0));
    vecs.push_back(mv(mk(2, 14,1,3,0, 0,0,0,0),   77,    77,  0,0,0,0,0));
    vecs.push_back(mv(mk(2, 3,1,3,2, 0,0,0,0),    -5,    -5,  0,0,0,0,0));
    vecs.push_back(mv(mk(2, 3,1,3,0, 31,3,31,3),   1,   101,  3,1,0,0,0));
    vecs.push_back(mv(mk(3, 3,1,3,0, 13,1,13,1),   0,   100,  3,1,13,1,1));
    vecs.push_back(mv(mk(2, 7,0,8,0, 0,0,0,0),  1000,   950,  7,0,0,0,0));
    vecs.push_back(mv(mk(0, 3,1,3,0, 0,0,0,0),     9,     9,  0,0,0,0,0));

    foreach (vecs[i]) begin
      string nm = $sformatf("vec%0d", i);
      run_q.delete();
      run_q.push_back(vecs[i].t);
      model_run(vecs[i].base, em, er1, ec1, er2, ec2, etwo);
      do_run(nm, vecs[i].base, 0, lat);
      check_run(nm, lat, vecs[i].em, vecs[i].er1, vecs[i].ec1,
                vecs[i].er2, vecs[i].ec2, vecs[i].etwo);
    end

    // tie at 40: the earlier single-row candidate must survive
    run_q.delete();
    run_q.push_back(mk(2, 10,1,8,0, 0,0,0,0));
    run_q.push_back(mk(3, 2,1,8,0, 2,1,9,0));
    model_run(0, em, er1, ec1, er2, ec2, etwo);
    do_run("tie", 0, 0, lat);
    check_run("tie", lat, 40, 10, 1, 0, 0, 0);

    // later better candidate replaces earlier, ignored phases in between
    run_q.delete();
    run_q.push_back(mk(2, 2,1,8,0, 0,0,0,0));
    run_q.push_back(mk(1, 3,1,8,0, 0,0,0,0));
    run_q.push_back(mk(2, 3,1,8,0, 0,0,0,0));
    run_q.push_back(mk(2, 5,1,8,0, 0,0,0,0));
    model_run(0, em, er1, ec1, er2, ec2, etwo);
    do_run("seq", 0, 1, lat);
    check_run("seq", lat, 100, 3, 1, 0, 0, 0);

    // reset in the middle of a run: no pulse, idle, table cleared
    run_q.delete();
    drive_tuple(mk(2, 3,1,3,0, 0,0,0,0));
    base_metric = 0;
    idx_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.busy_before", int'(busy), 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    drive_idle();
    chk("abort.busy", int'(busy), 0);
    chk("abort.metric", int'(best_metric), 0);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (best_valid) pulses++;
    end
    chk("abort.no_pulse", pulses, 0);
    for (int r = 0; r < J; r++) for (int c = 0; c < A; c++) T[r][c] = 0;
    m_cand = 0; m_err = 0;
    run_q.push_back(mk(3, 3,1,3,0, 10,1,2,1));
    model_run(5, em, er1, ec1, er2, ec2, etwo);
    do_run("post_reset", 5, 0, lat);
    check_run("post_reset", lat, 5, 3, 1, 10, 1, 1);

    // randomized runs against the reference model
    for (int r = 0; r < 30; r++) begin
      string nm = $sformatf("rnd%0d", r);
      int base;
      for (int w = 0; w < 3; w++) begin
        int d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                            : int'($urandom_range(0, 65535)) - 32768;
        write_tbl($urandom_range(0, J - 1), $urandom_range(0, A - 1), d);
      end
      run_q.delete();
      nt = $urandom_range(1, 8);
      for (int k = 0; k < nt; k++) begin
        tup_t t;
        t.si  = $urandom_range(0, 3);
        t.mr1 = ($urandom_range(0, 99) < 6) ? $urandom_range(14, 31) : $urandom_range(0, 13);
        t.dr1 = ($urandom_range(0, 99) < 6) ? $urandom_range(14, 31) : $urandom_range(0, 13);
        t.mr2 = ($urandom_range(0, 99) < 6) ? $urandom_range(14, 31) : $urandom_range(0, 13);
        t.dr2 = ($urandom_range(0, 99) < 6) ? $urandom_range(14, 31) : $urandom_range(0, 13);
        t.mc1 = ($urandom_range(0, 99) < 6) ? $urandom_range(2, 3) : $urandom_range(0, 1);
        t.dc1 = ($urandom_range(0, 99) < 6) ? $urandom_range(2, 3) : $urandom_range(0, 1);
        t.mc2 = ($urandom_range(0, 99) < 6) ? $urandom_range(2, 3) : $urandom_range(0, 1);
        t.dc2 = ($urandom_range(0, 99) < 6) ? $urandom_range(2, 3) : $urandom_range(0, 1);
        run_q.push_back(t);
      end
      base = int'($urandom_range(0, 65535)) - 32768;
      model_run(base, em, er1, ec1, er2, ec2, etwo);
      do_run(nm, base, r[0], lat);
      check_run(nm, lat, em, er1, ec1, er2, ec2, etwo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
